// File: rtl/rst_req_gen_if.sv
// rtl/rst_req_gen_if.sv - request/acknowledge/cause bundle between reset requesters and rst_req_gen
interface rst_req_gen_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0] req_i;
    logic               cause_clr_i;
    logic               rst_n_o;
    logic               busy_o;
    logic               req_ack_o;
    logic [NUM_REQ-1:0] cause_o;

    modport master (
        output req_i,
        output cause_clr_i,
        input  rst_n_o,
        input  busy_o,
        input  req_ack_o,
        input  cause_o
    );

    modport slave (
        input  req_i,
        input  cause_clr_i,
        output rst_n_o,
        output busy_o,
        output req_ack_o,
        output cause_o
    );
endinterface

// File: rtl/rst_req_gen.sv
// rtl/rst_req_gen.sv - stretches synchronous reset requests into a minimum-width active-low reset
module rst_req_gen #(
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_REQ     = 2,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rst_req_gen_if.slave   bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HOLD     = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("rst_req_gen: HOLD_CYCLES must be >= 1");
        end
        if (NUM_REQ < 1) begin : g_bad_num_req
            $error("rst_req_gen: NUM_REQ must be >= 1");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rst_n;
    logic               r_busy;
    logic               r_ack;
    logic [NUM_REQ-1:0] r_cause;
    logic               w_any_req;

    assign w_any_req = |bus.req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_rst_n <= 1'b0;
            r_busy  <= 1'b1;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                        r_rst_n <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ack   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Late requests extend the pulse via WAIT_REL rather than restarting the count.
                    if (r_cnt == CNT_LAST) begin
                        if (w_any_req) begin
                            r_state <= ST_WAIT_REL;
                        end else begin
                            r_state <= ST_IDLE;
                            r_rst_n <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    if (!w_any_req) begin
                        r_state <= ST_IDLE;
                        r_rst_n <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= '0;
                    r_rst_n <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Any asserted request is a reset cause in every state; a clear only drops older bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cause <= '0;
        end else begin
            r_cause <= (bus.cause_clr_i ? '0 : r_cause) | bus.req_i;
        end
    end

    assign bus.rst_n_o   = r_rst_n;
    assign bus.busy_o    = r_busy;
    assign bus.req_ack_o = r_ack;
    assign bus.cause_o   = r_cause;
endmodule

// File: tb/tb_rst_req_gen.sv
// tb/tb_rst_req_gen.sv - directed self-checking bench for rst_req_gen (HOLD_CYCLES 16 and 1)
module tb_rst_req_gen;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rst_req_gen_if #(.NUM_REQ(2)) if0 ();
    rst_req_gen_if #(.NUM_REQ(2)) if1 ();

    rst_req_gen #(.HOLD_CYCLES(16), .NUM_REQ(2)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0.slave)
    );

    rst_req_gen #(.HOLD_CYCLES(1), .NUM_REQ(2)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges until rst_n_o rises (bounded); reports whether an ack appeared meanwhile.
    task automatic wait_release(output int edges, output int acks);
        edges = 0;
        acks  = 0;
        do begin
            @(negedge clk);
            edges++;
            if (if0.req_ack_o) acks++;
        end while (!if0.rst_n_o && edges < 200);
    endtask

    task automatic pulse_clr();
        if0.cause_clr_i = 1'b1;
        @(negedge clk);
        if0.cause_clr_i = 1'b0;
    endtask

    int edges;
    int acks;
    int lows;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        if0.req_i = 2'b00; if0.cause_clr_i = 1'b0;
        if1.req_i = 2'b00; if1.cause_clr_i = 1'b0;
        repeat (5) @(negedge clk);

        check("por_rst_n", if0.rst_n_o, 0);
        check("por_busy", if0.busy_o, 1);
        check("por_ack", if0.req_ack_o, 0);
        check("por_cause", if0.cause_o, 0);

        // Power-on: release exactly 16 edges after rst drops, no ack.
        rst = 1'b0;
        wait_release(edges, acks);
        check("por_release_edges", edges, 16);
        check("por_acks", acks, 0);
        check("por_busy_fall", if0.busy_o, 0);
        check("por_cause_after", if0.cause_o, 0);

        // Single-cycle request from source 0.
        if0.req_i = 2'b01;
        @(negedge clk);
        check("req0_rst_n", if0.rst_n_o, 0);
        check("req0_ack", if0.req_ack_o, 1);
        check("req0_busy", if0.busy_o, 1);
        if0.req_i = 2'b00;
        wait_release(edges, acks);
        check("req0_edges", edges, 16);
        check("req0_acks", acks, 0);
        check("req0_cause", if0.cause_o, 2'b01);
        pulse_clr();
        check("clr_cause", if0.cause_o, 0);

        // Request from source 1 held for 40 cycles.
        if0.req_i = 2'b10;
        @(negedge clk);
        check("held_ack", if0.req_ack_o, 1);
        lows = 0; acks = 0;
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            if (!if0.rst_n_o) lows++;
            if (if0.req_ack_o) acks++;
        end
        check("held_low_cycles", lows, 39);
        check("held_extra_acks", acks, 0);
        if0.req_i = 2'b00;
        @(negedge clk);
        check("held_release", if0.rst_n_o, 1);
        check("held_busy", if0.busy_o, 0);
        check("held_cause", if0.cause_o, 2'b10);
        pulse_clr();

        // Second source pulsed during HOLD: no new ack, no restart.
        if0.req_i = 2'b01;
        @(negedge clk);
        check("mix_ack", if0.req_ack_o, 1);
        if0.req_i = 2'b00;
        repeat (4) @(negedge clk);
        if0.req_i = 2'b10;
        @(negedge clk);
        check("mix_ack_in_hold", if0.req_ack_o, 0);
        if0.req_i = 2'b00;
        wait_release(edges, acks);
        check("mix_edges", edges + 5, 16);
        check("mix_acks", acks, 0);
        check("mix_cause", if0.cause_o, 2'b11);
        pulse_clr();
        check("mix_clr", if0.cause_o, 0);

        // Clear coincident with a new capture keeps only the new bits.
        if0.req_i = 2'b10;
        @(negedge clk);
        if0.req_i = 2'b00;
        wait_release(edges, acks);
        check("pre_cause", if0.cause_o, 2'b10);
        if0.req_i = 2'b01;
        if0.cause_clr_i = 1'b1;
        @(negedge clk);
        if0.req_i = 2'b00;
        if0.cause_clr_i = 1'b0;
        check("clrset_cause", if0.cause_o, 2'b01);
        check("clrset_ack", if0.req_ack_o, 1);
        wait_release(edges, acks);
        check("clrset_edges", edges, 16);

        // Asynchronous reset mid-HOLD aborts and restarts the full hold.
        if0.req_i = 2'b01;
        @(negedge clk);
        if0.req_i = 2'b00;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rst_n", if0.rst_n_o, 0);
        check("abort_cause", if0.cause_o, 0);
        check("abort_busy", if0.busy_o, 1);
        @(negedge clk);
        rst = 1'b0;
        wait_release(edges, acks);
        check("abort_edges", edges, 16);
        check("abort_acks", acks, 0);

        // HOLD_CYCLES=1 instance: one-cycle reset pulse.
        check("h1_idle", if1.rst_n_o, 1);
        if1.req_i = 2'b01;
        @(negedge clk);
        check("h1_low", if1.rst_n_o, 0);
        check("h1_ack", if1.req_ack_o, 1);
        if1.req_i = 2'b00;
        @(negedge clk);
        check("h1_release", if1.rst_n_o, 1);
        check("h1_busy", if1.busy_o, 0);
        check("h1_cause", if1.cause_o, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
